// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the parametrised FIFO family.
//   clog2()     : ceiling log2, for callers that derive ADDR_WIDTH from a depth
//   ptr_width() : pointer width convention, ADDR_WIDTH plus one wrap bit
package fifo_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // The extra MSB distinguishes full from empty when the low bits match.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// DEPTH x DATA_WIDTH storage for fifo_param: one synchronous write port,
// one asynchronous read port.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset; the pointers alone decide which
   // entries are valid, so clearing it would only cost area and timing.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param
// Parametrised single-clock first-word-fall-through FIFO with occupancy
// count, programmable almost-full/almost-empty flags, synchronous flush
// and sticky overflow/underflow flags.
//   clk             : clock, rising edge
//   reset           : synchronous, active-low
//   io_din          : write data
//   io_push         : write request
//   io_pop          : read request, consumes the entry on io_dout
//   io_clear        : synchronous flush of pointers and count
//   io_err_clr      : clears the sticky error flags
//   io_dout         : head entry, valid while !io_empty
//   io_empty        : count == 0
//   io_full         : count == DEPTH
//   io_almost_empty : count <= AEMPTY_LEVEL
//   io_almost_full  : count >= AFULL_LEVEL
//   io_count        : occupancy, 0..DEPTH
//   io_overflow     : sticky, a push was rejected
//   io_underflow    : sticky, a pop was rejected
module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 1,
   parameter int AEMPTY_LEVEL = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] io_din,
   input  logic                  io_push,
   input  logic                  io_pop,
   input  logic                  io_clear,
   input  logic                  io_err_clr,
   output logic [DATA_WIDTH-1:0] io_dout,
   output logic                  io_empty,
   output logic                  io_full,
   output logic                  io_almost_empty,
   output logic                  io_almost_full,
   output logic [ADDR_WIDTH:0]   io_count,
   output logic                  io_overflow,
   output logic                  io_underflow
);

   localparam int PTR_W = ptr_width(ADDR_WIDTH);
   localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_LEVEL);
   localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_LEVEL);
   localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] count;
   logic             overflow;
   logic             underflow;

   logic             empty;
   logic             full;
   logic             pop_ok;
   logic             push_ok;
   logic             ovf_set;
   logic             unf_set;

   // Status decoded from registers only, so no input reaches an output
   // combinationally.
   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[ADDR_WIDTH-1:0] == wr_ptr[ADDR_WIDTH-1:0]) &&
                  (rd_ptr[ADDR_WIDTH] != wr_ptr[ADDR_WIDTH]);

   // A pop frees the slot this cycle, so a push into a full FIFO is accepted
   // alongside it. Flush swallows both requests and raises no error.
   assign pop_ok  = io_pop & ~empty & ~io_clear;
   assign push_ok = io_push & (~full | pop_ok) & ~io_clear;
   assign ovf_set = io_push & ~push_ok & ~io_clear;
   assign unf_set = io_pop & ~pop_ok & ~io_clear;

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (io_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr <= wr_ptr + ONE;
            end
            if (pop_ok) begin
               rd_ptr <= rd_ptr + ONE;
            end
            if (push_ok && !pop_ok) begin
               count <= count + ONE;
            end else if (pop_ok && !push_ok) begin
               count <= count - ONE;
            end
         end
         // A new error in the same cycle as io_err_clr stays visible.
         overflow  <= ovf_set | (overflow & ~io_err_clr);
         underflow <= unf_set | (underflow & ~io_err_clr);
      end
   end

   fifo_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (push_ok & reset),
      .waddr(wr_ptr[ADDR_WIDTH-1:0]),
      .wdata(io_din),
      .raddr(rd_ptr[ADDR_WIDTH-1:0]),
      .rdata(io_dout)
   );

   assign io_empty        = empty;
   assign io_full         = full;
   assign io_almost_empty = (count <= AEMPTY_C);
   assign io_almost_full  = (count >= AFULL_C);
   assign io_count        = count;
   assign io_overflow     = overflow;
   assign io_underflow    = underflow;

endmodule
